// File: rtl/gerador_comandos.sv
// gerador_comandos: debounces two active-low pushbuttons and issues one-strobe step commands.
// Optional build macro AUTO_REPEAT_EN re-issues the command while a single key stays held.
module gerador_comandos #(
   parameter int DEBOUNCE = 50000,
   parameter int REPEAT   = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_avanca,
   input  logic       key_volta,
   output logic [1:0] entradas,
   output logic       passo,
   output logic       ocupado
);

   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_RELEASE} state_t;

   logic [1:0] key_raw;
   logic [1:0] deb_level;
   logic [1:0] press;
   logic [1:0] cmd_next;
   logic [1:0] cmd_reg;
   state_t     state_reg;

   assign key_raw = {key_volta, key_avanca};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         logic        sync1_reg;
         logic        sync2_reg;
         logic        deb_reg;
         logic        prev_reg;
         logic [19:0] cnt_reg;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sync1_reg <= 1'b1;
               sync2_reg <= 1'b1;
               deb_reg   <= 1'b1;
               prev_reg  <= 1'b1;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= key_raw[gi];
               sync2_reg <= sync1_reg;
               prev_reg  <= deb_reg;
               // counter tracks how long the synchronized level has disagreed
               if (sync2_reg != deb_reg) begin
                  if (cnt_reg == DB_LAST) begin
                     deb_reg <= sync2_reg;
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 20'd1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign deb_level[gi] = deb_reg;
         assign press[gi]     = prev_reg & ~deb_reg;
      end
   endgenerate

   always_comb begin
      cmd_next = 2'b10;
      if (deb_level == 2'b00) begin
         cmd_next = 2'b11;
      end else if (press[0]) begin
         cmd_next = 2'b01;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam logic [24:0] RP_LAST = 25'(REPEAT - 1);
   logic [24:0] rpt_reg;
`else
   // REPEAT only matters to the auto-repeat build; referenced here to keep it visible
   if (REPEAT < 2) begin : g_repeat_unused
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cmd_reg   <= 2'b00;
         entradas  <= 2'b00;
         passo     <= 1'b0;
         ocupado   <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rpt_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (|press) begin
                  cmd_reg   <= cmd_next;
                  entradas  <= cmd_next;
                  ocupado   <= 1'b1;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               passo     <= 1'b1;
               state_reg <= STROBE;
            end
            STROBE: begin
               passo     <= 1'b0;
               state_reg <= HOLD;
            end
            HOLD: begin
               entradas  <= 2'b00;
               state_reg <= WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
               if (&deb_level) begin
                  ocupado   <= 1'b0;
                  state_reg <= IDLE;
`ifdef AUTO_REPEAT_EN
                  rpt_reg   <= '0;
               end else if ((deb_level[0] ^ deb_level[1]) && (cmd_reg != 2'b11)) begin
                  if (rpt_reg == RP_LAST) begin
                     rpt_reg   <= '0;
                     entradas  <= cmd_reg;
                     state_reg <= SETUP;
                  end else begin
                     rpt_reg <= rpt_reg + 25'd1;
                  end
               end else begin
                  rpt_reg <= '0;
`endif
               end
            end
            default: begin
               entradas  <= 2'b00;
               passo     <= 1'b0;
               ocupado   <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gerador_comandos.sv
// Bench for gerador_comandos with DEBOUNCE=4, REPEAT=20; honours AUTO_REPEAT_EN like the design.
module tb_gerador_comandos;

   localparam int D = 4;
   localparam int R = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_avanca = 1'b1;
   logic       key_volta = 1'b1;
   logic [1:0] entradas;
   logic       passo;
   logic       ocupado;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   gerador_comandos #(.DEBOUNCE(D), .REPEAT(R)) dut (
      .clock      (clock),
      .reset      (reset),
      .key_avanca (key_avanca),
      .key_volta  (key_volta),
      .entradas   (entradas),
      .passo      (passo),
      .ocupado    (ocupado)
   );

   // Reference model: keys as sample histories and run lengths, command as a phase number
   // (-1 idle, 0..2 the setup/strobe/hold window, 3 waiting for release).
   logic [1:0] m_s1, m_s2, m_deb, m_prev, m_cmd, m_raw;
   int         m_run [2];
   int         m_phase, m_wait;
   logic [1:0] exp_ent;
   logic       exp_passo, exp_busy;

   task automatic model_reset();
      m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_prev = 2'b11; m_cmd = 2'b00;
      m_run[0] = 0; m_run[1] = 0; m_phase = -1; m_wait = 0;
      exp_ent = 2'b00; exp_passo = 1'b0; exp_busy = 1'b0;
   endtask

   task automatic model_step();
      if (!reset) begin
         model_reset();
      end else begin
         m_raw = {key_volta, key_avanca};
         if (m_phase < 0) begin
            if (|(m_prev & ~m_deb)) begin
               m_cmd   = (m_deb == 2'b00) ? 2'b11 : (!m_deb[0] ? 2'b01 : 2'b10);
               m_phase = 0;
            end
         end else if (m_phase < 3) begin
            m_phase++;
         end else if (m_deb == 2'b11) begin
            m_phase = -1;
            m_wait  = 0;
         end
`ifdef AUTO_REPEAT_EN
         else if ((m_deb == 2'b01 || m_deb == 2'b10) && m_cmd != 2'b11) begin
            m_wait++;
            if (m_wait == R) begin
               m_wait  = 0;
               m_phase = 0;
            end
         end else begin
            m_wait = 0;
         end
`endif
         for (int k = 0; k < 2; k++) begin
            m_prev[k] = m_deb[k];
            if (m_s2[k] != m_deb[k]) begin
               m_run[k]++;
               if (m_run[k] == D) begin
                  m_deb[k] = m_s2[k];
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = m_raw[k];
         end
         exp_ent   = (m_phase >= 0 && m_phase <= 2) ? m_cmd : 2'b00;
         exp_passo = (m_phase == 1);
         exp_busy  = (m_phase >= 0);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #2;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      tick();
      n_cmp++;
      if ({entradas, passo, ocupado} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_hold got=%b required=0000", {entradas, passo, ocupado});
      end
      tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy} || ocupado !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release got=%b required=%b", {entradas, passo, ocupado},
                  {exp_ent, exp_passo, exp_busy});
      end
      $display("reset: outputs=%b", {entradas, passo, ocupado});
   endtask

   task automatic test_single_press();
      int pulses = 0;
      key_avanca = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL single e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (passo === 1'b1) begin
            pulses++;
            $display("single: passo edge %0d cmd=%b", e, entradas);
         end
         if (e == 6 || e == 7 || e == 10) begin
            n_cmp++;
            if (entradas !== ((e == 7) ? 2'b01 : 2'b00)) begin
               n_bad++;
               $display("FAIL single_latency e=%0d got=%b required=%b", e, entradas,
                        (e == 7) ? 2'b01 : 2'b00);
            end
         end
         if (e == 7 || e == 8) begin
            n_cmp++;
            if (passo !== (e == 8)) begin
               n_bad++;
               $display("FAIL single_strobe e=%0d got=%b required=%b", e, passo, (e == 8));
            end
         end
      end
      n_cmp++;
      if (pulses != 1) begin
         n_bad++;
         $display("FAIL single_count got=%0d required=1", pulses);
      end
      key_avanca = 1'b1;
      settle(20);
   endtask

   task automatic test_glitch();
      int pulses = 0;
      key_volta = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (e == 3) key_volta = 1'b1;
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL glitch e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (passo !== 1'b0 || entradas !== 2'b00) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++;
         $display("FAIL glitch_quiet active_cycles=%0d required=0", pulses);
      end
      $display("glitch: short press filtered");
   endtask

   task automatic test_both();
      int         pulses = 0;
      logic [1:0] seen = 2'b00;
      key_avanca = 1'b0;
      key_volta  = 1'b0;
      for (int e = 1; e <= 80; e++) begin
         tick();
         if (e == 60) begin
            key_avanca = 1'b1;
            key_volta  = 1'b1;
         end
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL both e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (passo === 1'b1) begin
            pulses++;
            seen = entradas;
            $display("both: passo edge %0d cmd=%b", e, entradas);
         end
      end
      n_cmp++;
      if (pulses != 1 || seen !== 2'b11) begin
         n_bad++;
         $display("FAIL both_cmd pulses=%0d cmd=%b required 1 pulse cmd=11", pulses, seen);
      end
   endtask

   task automatic test_second_key();
      logic [1:0] cmds [$];
      key_avanca = 1'b0;
      for (int e = 1; e <= 120; e++) begin
         tick();
         if (e == 20) key_volta = 1'b0;
         if (e == 60) begin
            key_avanca = 1'b1;
            key_volta  = 1'b1;
         end
         if (e == 80) key_volta = 1'b0;
         if (e == 95) key_volta = 1'b1;
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL second_key e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (passo === 1'b1) begin
            cmds.push_back(entradas);
            $display("second_key: passo edge %0d cmd=%b", e, entradas);
         end
      end
      n_cmp++;
      if (cmds.size() != 2) begin
         n_bad++;
         $display("FAIL second_key_count got=%0d required=2", cmds.size());
      end else if (cmds[0] !== 2'b01 || cmds[1] !== 2'b10) begin
         n_bad++;
         $display("FAIL second_key_cmds got=%b,%b required=01,10", cmds[0], cmds[1]);
      end
   endtask

   task automatic test_reset_mid();
      key_avanca = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL reset_mid_pre e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
      end
      #1 reset = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({entradas, passo, ocupado} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_mid_abort got=%b required=0000", {entradas, passo, ocupado});
      end
      tick();
      tick();
      reset = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         tick();
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL reset_mid_post e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (e == 6 || e == 7) begin
            n_cmp++;
            if (entradas !== ((e == 7) ? 2'b01 : 2'b00)) begin
               n_bad++;
               $display("FAIL reset_mid_latency e=%0d got=%b required=%b", e, entradas,
                        (e == 7) ? 2'b01 : 2'b00);
            end
         end
      end
      $display("reset_mid: command reissued after release");
      key_avanca = 1'b1;
      settle(20);
   endtask

   task automatic test_repeat();
      int pe [$];
      key_avanca = 1'b0;
      for (int e = 1; e <= 130; e++) begin
         tick();
         if (e == 100) key_avanca = 1'b1;
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL repeat e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (passo === 1'b1) begin
            pe.push_back(e);
            $display("repeat: passo edge %0d cmd=%b", e, entradas);
         end
      end
`ifdef AUTO_REPEAT_EN
      n_cmp++;
      if (pe.size() != 5) begin
         n_bad++;
         $display("FAIL repeat_count got=%0d required=5", pe.size());
      end else begin
         foreach (pe[i]) begin
            n_cmp++;
            if (pe[i] != 8 + 23 * i) begin
               n_bad++;
               $display("FAIL repeat_edge idx=%0d got=%0d required=%0d", i, pe[i], 8 + 23 * i);
            end
         end
      end
`else
      n_cmp++;
      if (pe.size() != 1 || pe[0] != 8) begin
         n_bad++;
         $display("FAIL repeat_single pulses=%0d required 1 at edge 8", pe.size());
      end
`endif
   endtask

   task automatic test_random();
      int hold_a = 0;
      int hold_v = 0;
      for (int e = 1; e <= 1500; e++) begin
         tick();
         n_cmp++;
         if ({entradas, passo, ocupado} !== {exp_ent, exp_passo, exp_busy}) begin
            n_bad++;
            $display("FAIL random e=%0d got=%b required=%b", e, {entradas, passo, ocupado},
                     {exp_ent, exp_passo, exp_busy});
         end
         if (passo === 1'b1) $display("random: passo edge %0d cmd=%b", e, entradas);
         if (hold_a == 0) begin
            key_avanca = 1'($urandom_range(0, 1));
            hold_a     = $urandom_range(1, 14);
         end else begin
            hold_a--;
         end
         if (hold_v == 0) begin
            key_volta = 1'($urandom_range(0, 1));
            hold_v    = $urandom_range(1, 14);
         end else begin
            hold_v--;
         end
      end
      key_avanca = 1'b1;
      key_volta  = 1'b1;
      settle(20);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_press();
      test_glitch();
      test_both();
      test_second_key();
      test_reset_mid();
      test_repeat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gerador_comandos.md
GERADOR_COMANDOS -- requirements
Module: gerador_comandos

Interface
REQ-001 Parameter DEBOUNCE, default 50000: consecutive clock cycles a synchronized button level must hold before it is accepted; legal range 2..1048575.
REQ-002 Parameter REPEAT, default 25000000: auto-repeat period in clock cycles; legal range 2..33554431; used only when AUTO_REPEAT_EN is defined.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key_avanca  input  1  raw "forward" pushbutton, active-low, asynchronous to clock.
REQ-006 key_volta  input  1  raw "back" pushbutton, active-low, asynchronous to clock.
REQ-007 entradas  output  2  step command to the display state machine: 00 hold, 01 forward, 10 back, 11 blank.
REQ-008 passo  output  1  one-cycle strobe; the display state machine registers entradas on its rising edge.
REQ-009 ocupado  output  1  high whenever the command FSM is not in IDLE.

Function
REQ-010 Each key SHALL pass through a 2-flop synchronizer whose flops are initialized to released (1).
REQ-011 Each synchronized key SHALL have a 20-bit debounce counter: it clears while the synchronized level equals the debounced level and increments while they differ.
REQ-012 The debounced level SHALL take the synchronized value on the edge at which the levels have differed for DEBOUNCE consecutive cycles; a mismatch shorter than DEBOUNCE cycles SHALL leave the debounced level unchanged.
REQ-013 A press event SHALL be the debounced level going from released to pressed; release edges SHALL produce no command.
REQ-014 The command FSM SHALL have five states: IDLE, SETUP, STROBE, HOLD, WAIT_RELEASE.
REQ-015 IDLE: entradas=00, passo=0. On a press event it SHALL load cmd and go to SETUP, with cmd = 01 for key_avanca alone, 10 for key_volta alone, and 11 when both debounced levels are pressed in that cycle.
REQ-016 SETUP: entradas=cmd, passo=0, for exactly 1 cycle, then STROBE.
REQ-017 STROBE: entradas=cmd, passo=1, for exactly 1 cycle, then HOLD.
REQ-018 HOLD: entradas=cmd, passo=0, for exactly 1 cycle, then WAIT_RELEASE.
REQ-019 WAIT_RELEASE: entradas=00, passo=0. It SHALL return to IDLE only when both debounced keys are released.
REQ-020 Press events arriving in SETUP, STROBE, HOLD or WAIT_RELEASE SHALL be ignored, including a second key pressed while the first is held.
REQ-021 Exactly one passo pulse SHALL be emitted per accepted command; entradas SHALL be stable from 1 cycle before to 1 cycle after passo.
REQ-022 Latency: entradas=cmd SHALL appear 1 edge after the press event, which is DEBOUNCE+3 edges after the raw key falls and stays low.

Reset
REQ-023 Asserting reset SHALL immediately force: FSM to IDLE, entradas=00, passo=0, ocupado=0, synchronizers and debounced levels to released, all counters to 0.
REQ-024 Reset asserted mid-command SHALL abort the command with no further passo pulse.
REQ-025 A key still held when reset is released SHALL be treated as a new press, producing a command DEBOUNCE+3 edges after reset is deasserted.

Configuration
REQ-026 Macro AUTO_REPEAT_EN defined: in WAIT_RELEASE with exactly one key held and cmd≠11, a 25-bit repeat counter SHALL count cycles; on reaching REPEAT it SHALL clear and move to SETUP with the same cmd, repeating every REPEAT+3 cycles for as long as the key is held.
REQ-027 Macro AUTO_REPEAT_EN undefined: there SHALL be no repeat counter and exactly one command per press.

Verification (DEBOUNCE=4, REPEAT=20)
REQ-028 key_avanca low from edge 0 and held -> entradas=01 after edge 7, passo=1 only after edge 8, entradas=00 after edge 10, no further pulse while held (macro off).
REQ-029 key_volta low for 3 cycles, then high -> entradas stays 00 and passo never asserts.
REQ-030 Both keys fall on the same edge and are held -> single command 11 with one passo pulse, no repeat even with the macro on.
REQ-031 key_avanca held; key_volta pressed 20 cycles later -> only the 01 command occurs; a new key_volta press after both are released -> command 10.
REQ-032 reset pulsed low during STROBE while key_avanca is held -> outputs 00/0 immediately; after reset release, 01 after edge 7 relative to deassertion.
REQ-033 Macro on, key_avanca held 100 cycles -> first 01 command, then a passo every 23 cycles until release.
